// File: rtl/deb_pkg.sv
// Shared defaults for the multi-channel debouncer (deb_multi / deb_ch).
package deb_pkg;
  localparam int         DEB_CHANNELS    = 4;
  localparam int         DEB_CNT_W       = 8;
  localparam logic       DEB_OUT_RST     = 1'b1;
  localparam logic [7:0] DEB_THR_DEFAULT = 8'hFF;
endpackage

// File: rtl/deb_ch.sv
// Single-channel debouncer: 2-flop sync, saturating stability counter, registered rise/fall.
// A held input change reaches dout at edge thr+3; no backpressure. DEB_MULTI_TOGGLE_EN adds tgl.
module deb_ch
  import deb_pkg::*;
#(
  parameter int   CNT_W   = DEB_CNT_W,
  parameter logic OUT_RST = DEB_OUT_RST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [CNT_W-1:0] thr,
  output logic             dout,
  output logic             rise,
  output logic             fall
`ifdef DEB_MULTI_TOGGLE_EN
  ,
  output logic             tgl
`endif
);
  logic             s0;
  logic             s1;
  logic [CNT_W-1:0] cnt;
  logic             chg;
  logic             dout_nxt;

  assign chg      = s0 ^ s1;
  // thr is compared live, so a mid-count change takes effect without restarting cnt
  assign dout_nxt = (cnt >= thr) ? s1 : dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      cnt  <= '0;
      dout <= OUT_RST;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s0 <= din;
      s1 <= s0;
      if (chg)
        cnt <= '0;
      else if (cnt != {CNT_W{1'b1}})
        cnt <= cnt + CNT_W'(1);
      dout <= dout_nxt;
      rise <= ~dout & dout_nxt;
      fall <= dout & ~dout_nxt;
    end
  end

`ifdef DEB_MULTI_TOGGLE_EN
  // flips in the same cycle fall becomes visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tgl <= 1'b0;
    else if (dout & ~dout_nxt)
      tgl <= ~tgl;
  end
`endif
endmodule

// File: rtl/deb_multi.sv
// CHANNELS independent debouncers sharing one runtime threshold; optional tgl via DEB_MULTI_TOGGLE_EN.
// Held input change visible on out/rise/fall at edge thr+3; no handshake, outputs valid every cycle.
module deb_multi
  import deb_pkg::*;
#(
  parameter int   CHANNELS = DEB_CHANNELS,
  parameter int   CNT_W    = DEB_CNT_W,
  parameter logic OUT_RST  = DEB_OUT_RST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  input  logic [CNT_W-1:0]    thr,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
`ifdef DEB_MULTI_TOGGLE_EN
  ,
  output logic [CHANNELS-1:0] tgl
`endif
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    deb_ch #(
      .CNT_W  (CNT_W),
      .OUT_RST(OUT_RST)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (in[i]),
      .thr  (thr),
      .dout (out[i]),
      .rise (rise[i]),
      .fall (fall[i])
`ifdef DEB_MULTI_TOGGLE_EN
      ,
      .tgl  (tgl[i])
`endif
    );
  end
endmodule

// File: tb/tb_deb_multi.sv
// Randomised bench for deb_multi against a history-based reference model.
`timescale 1ns/1ps
module tb_deb_multi;
  localparam int   CH   = 4;
  localparam int   CW   = 8;
  localparam logic ORST = 1'b1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH-1:0] in_r  = '1;
  logic [CW-1:0] thr_r = 8'd10;
  logic [CH-1:0] out_w, rise_w, fall_w;
`ifdef DEB_MULTI_TOGGLE_EN
  logic [CH-1:0] tgl_w;
`endif

  int            total = 0;
  int            bad   = 0;
  bit            chk_en = 1'b0;
  logic [CH-1:0] pulse_acc = '0;

  always #5 clk = ~clk;

  deb_multi #(.CHANNELS(CH), .CNT_W(CW), .OUT_RST(ORST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in_r),
    .thr  (thr_r),
    .out  (out_w),
    .rise (rise_w),
    .fall (fall_w)
`ifdef DEB_MULTI_TOGGLE_EN
    ,
    .tgl  (tgl_w)
`endif
  );

  // Model: per channel, the list of sampled inputs since reset (two reset zeros first).
  // At each edge the synchronised value is the second-newest sample; it is accepted when
  // it has been the same for at least thr+1 consecutive samples.
  bit            hq [CH][$];
  logic [CH-1:0] m_out, m_rise, m_fall, m_tgl;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      hq[c].delete();
      hq[c].push_back(1'b0);
      hq[c].push_back(1'b0);
    end
    m_out  = {CH{ORST}};
    m_rise = '0;
    m_fall = '0;
    m_tgl  = '0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] nxt;
    nxt = m_out;
    for (int c = 0; c < CH; c++) begin
      int last, run;
      bit v;
      last = hq[c].size() - 2;
      v    = hq[c][last];
      run  = 0;
      for (int k = last; k >= 0; k--) begin
        if (hq[c][k] != v) break;
        run++;
      end
      if (run - 1 >= int'(thr_r)) nxt[c] = v;
      hq[c].push_back(in_r[c]);
      if (hq[c].size() > 320) void'(hq[c].pop_front());
    end
    m_rise = ~m_out & nxt;
    m_fall = m_out & ~nxt;
    m_tgl  = m_tgl ^ m_fall;
    m_out  = nxt;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  task automatic chk(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out", out_w, m_out);
      chk("model_rise", rise_w, m_rise);
      chk("model_fall", fall_w, m_fall);
`ifdef DEB_MULTI_TOGGLE_EN
      chk("model_tgl", tgl_w, m_tgl);
`endif
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      pulse_acc = pulse_acc | rise_w | fall_w;
    end
  endtask

  // Called just after a negedge: asserts reset mid-cycle, checks it took effect at once.
  task automatic reset_pulse(input logic [CH-1:0] in_during);
    #2 rst_n = 1'b0;
    in_r = in_during;
    #1;
    chk("rst_out", out_w, {CH{ORST}});
    chk("rst_rise", rise_w, '0);
    chk("rst_fall", fall_w, '0);
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("init_out", out_w, 4'b1111);
    chk("init_rise", rise_w, 4'b0000);
    chk("init_fall", fall_w, 4'b0000);
    chk_en = 1'b1;
    run(2);
    rst_n = 1'b1;
    pulse_acc = '0;
    run(20);
    chk("idle_out", out_w, 4'b1111);
    chk("idle_pulses", pulse_acc, 4'b0000);

    // single press on channel 0, thr = 10
    in_r[0] = 1'b0;
    run(12);
    chk("c0_e12_out", out_w, 4'b1111);
    run(1);
    chk("c0_e13_out", out_w, 4'b1110);
    chk("c0_e13_fall", fall_w, 4'b0001);
    chk("c0_e13_rise", rise_w, 4'b0000);
    run(1);
    chk("c0_e14_fall", fall_w, 4'b0000);

    // bounce on channel 1 every 5 cycles
    pulse_acc = '0;
    for (int k = 0; k < 20; k++) begin
      in_r[1] = ~in_r[1];
      run(5);
    end
    chk("bounce_out", out_w, 4'b1110);
    chk("bounce_pulses", pulse_acc, 4'b0000);
    in_r[1] = 1'b0;
    run(12);
    chk("c1_e12_out", out_w, 4'b1110);
    run(1);
    chk("c1_e13_out", out_w, 4'b1100);
    chk("c1_e13_fall", fall_w, 4'b0010);

    // thr = 0: pure synchroniser on channel 2
    thr_r   = 8'd0;
    in_r[2] = 1'b0;
    run(2);
    chk("thr0_e2_out", out_w, 4'b1100);
    run(1);
    chk("thr0_e3_out", out_w, 4'b1000);
    chk("thr0_e3_fall", fall_w, 4'b0100);
    in_r[2] = 1'b1;
    run(3);
    chk("thr0_rise", rise_w, 4'b0100);
    run(1);
    for (int k = 0; k < 4; k++) begin
      in_r[2] = ~in_r[2];
      run(4);
    end
    run(6);
    chk("thr0_end_out", out_w, 4'b1100);

    // thr = all-ones on channel 3
    thr_r   = 8'hFF;
    in_r[3] = 1'b0;
    run(257);
    chk("sat_e257_out", out_w, 4'b1100);
    run(1);
    chk("sat_e258_out", out_w, 4'b0100);
    chk("sat_e258_fall", fall_w, 4'b1000);
    pulse_acc = '0;
    run(42);
    chk("sat_hold_pulses", pulse_acc, 4'b0000);
    chk("sat_hold_out", out_w, 4'b0100);

    // reset mid-count, then release with channel 0 low
    in_r[3] = 1'b1;
    run(100);
    thr_r = 8'd10;
    reset_pulse(4'b1110);
    run(10);
    chk("rel_e10_out", out_w, 4'b1111);
    run(1);
    chk("rel_e11_out", out_w, 4'b1110);
    chk("rel_e11_fall", fall_w, 4'b0001);
    in_r = 4'b1111;
    run(20);

`ifdef DEB_MULTI_TOGGLE_EN
    reset_pulse(4'b1111);
    run(20);
    chk("tgl_start", tgl_w, 4'b0000);
    for (int p = 0; p < 3; p++) begin
      in_r[0] = 1'b0;
      run(20);
      chk("tgl_press", tgl_w, (p % 2 == 0) ? 4'b0001 : 4'b0000);
      in_r[0] = 1'b1;
      run(20);
      chk("tgl_release", tgl_w, (p % 2 == 0) ? 4'b0001 : 4'b0000);
    end
`endif

    // randomised traffic, threshold changes and occasional resets
    for (int seg = 0; seg < 40; seg++) begin
      int rate;
      rate  = $urandom_range(3, 25);
      thr_r = CW'($urandom_range(0, 12));
      if (seg % 8 == 7) reset_pulse(CH'($urandom_range(0, 15)));
      for (int cyc = 0; cyc < 60; cyc++) begin
        for (int c = 0; c < CH; c++)
          if ($urandom_range(0, rate - 1) == 0) in_r[c] = ~in_r[c];
        if (cyc == 30 && $urandom_range(0, 1) == 1) thr_r = CW'($urandom_range(0, 12));
        run(1);
      end
    end
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/deb_multi.md
Name: deb_multi

Overview:
- Parametrised multi-channel debouncer: CHANNELS independent inputs, each with a 2-flop synchroniser, a saturating stability counter and a runtime-programmable threshold.
- Adds registered one-cycle rise/fall event pulses per channel.
- Sits between raw board inputs (buttons, switches) and control logic; replaces single-channel debouncers in the synthesis top.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- CNT_W, 8, stability counter width; also the width of the thr port.
- OUT_RST, 1'b1, reset value of every out bit (idle-high buttons).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in  input  CHANNELS  raw asynchronous inputs.
- thr  input  CNT_W  stable-cycle threshold, shared by all channels, sampled every cycle.
- out  output  CHANNELS  debounced level per channel.
- rise  output  CHANNELS  one-cycle pulse when out[i] goes 0->1.
- fall  output  CHANNELS  one-cycle pulse when out[i] goes 1->0.

Behaviour:
- Reset (async, immediate): sync flops = 0, cnt = 0, out = {CHANNELS{OUT_RST}}, rise = 0, fall = 0.
- Per channel i, each clk edge: s0 <= in[i]; s1 <= s0.
- chg = s0 ^ s1.
- cnt: cnt <= 0 if chg; else cnt <= cnt + 1, saturating at all-ones. Never wraps.
- out: out <= s1 if (cnt >= thr), else holds.
- rise <= ~out & out_next; fall <= out & ~out_next. Both are registered and coincide with the cycle the new out value is visible.
- Latency: with in[i] changed before edge 1 and held, out[i] takes the new value at edge thr+3.
- thr = 0: counter filtering disabled; out follows s1 (pure 3-edge synchroniser delay).
- Bounce shorter than thr+1 stable cycles: counter restarts; out unchanged, no pulses.
- thr changed mid-count: comparison uses the current thr value; no counter reset.
- thr = all-ones: output updates only after the counter saturates, then tracks s1 while stable.
- Reset mid-count: all state returns to reset values. After release, if s1 differs from OUT_RST and is stable, out transitions after thr+1 cycles and emits the matching pulse.
- Channels are fully independent; simultaneous events on several channels produce simultaneous pulses.
- No handshake; outputs are valid every cycle.

Optional Feature:
- Macro DEB_MULTI_TOGGLE_EN.
- Defined:
  - Adds output port tgl [CHANNELS-1:0], reset 0.
  - tgl[i] inverts on every cycle fall[i] is asserted (press-to-toggle for idle-high buttons).
  - rise does not affect tgl.
- Undefined: port tgl and its flops do not exist; all other behaviour is identical.

Decomposition:
- Package deb_pkg:
  - default constants DEB_CHANNELS = 4, DEB_CNT_W = 8.
  - DEB_OUT_RST = 1'b1.
  - DEB_THR_DEFAULT = 8'hFF, for tops tying thr.
- One sub-module deb_ch: single-channel synchroniser + counter + out/rise/fall (+ tgl under macro), parameterised by CNT_W and OUT_RST.
- deb_multi instantiates CHANNELS copies via generate.

Test Plan:
- Reset with in = 4'b1111, thr = 8'd10 -> out = 4'b1111, rise = fall = 0. Hold 20 cycles: no change, no pulses.
- in[0] 1->0 held, thr = 10 -> out[0] = 0 exactly at edge 13; fall[0] high for one cycle at that edge; other channels unaffected.
- in[1] bouncing 0/1 every 5 cycles for 100 cycles, thr = 10 -> out[1] never changes, no pulses. After settling at 0 -> fall[1] after 13 edges.
- thr = 0, in[2] toggled -> out[2] follows with 3-edge delay; rise/fall on every transition.
- in[3] stable for 300 cycles, thr = 8'hFF, CNT_W = 8 -> counter saturates at 255, no wrap, no spurious pulses. Assert rst_n mid-count -> immediate out = OUT_RST.
- With DEB_MULTI_TOGGLE_EN: three debounced presses on channel 0 -> tgl[0] sequence 1, 0, 1. Releases leave tgl unchanged.
